// File: rtl/otf_hd_pkg.sv
// Shared definitions for the online divider and its on-the-fly converter:
// signed-digit encoding and converter state encoding.
package otf_hd_pkg;

    typedef logic [1:0] digit_t;

    // Digit is {p,n} with value p-n; 2'b11 also means zero.
    localparam digit_t DIG_POS  = 2'b10;
    localparam digit_t DIG_NEG  = 2'b01;
    localparam digit_t DIG_ZERO = 2'b00;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

endpackage

// File: rtl/otf_convert_hd_if.sv
// Digit-in / word-out bus of the on-the-fly converter.
interface otf_convert_hd_if #(
    parameter int DIGITS = 32
);
    // Both directions use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds data steady while valid
    // is high and ready is low, and valid never waits on ready.
    logic [1:0]      q_value;
    logic            data_in_vld;
    logic            data_in_rdy;
    logic [DIGITS:0] result_value;
    logic            data_out_vld;
    logic            data_out_rdy;

    modport master (
        output q_value, data_in_vld, data_out_rdy,
        input  data_in_rdy, result_value, data_out_vld
    );

    modport slave (
        input  q_value, data_in_vld, data_out_rdy,
        output data_in_rdy, result_value, data_out_vld
    );
endinterface

// File: rtl/otf_step.sv
// One on-the-fly conversion step: next Q / QM from the current pair and one
// signed quotient digit (shift left, append, MSB dropped).
module otf_step
    import otf_hd_pkg::*;
#(
    parameter int W = 33
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_qm,
    input  digit_t       i_digit,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_qm
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        o_q  = (i_q << 1);
        o_qm = (i_qm << 1) | ONE;
        case (i_digit)
            DIG_POS: begin
                o_q  = (i_q << 1) | ONE;
                o_qm = (i_q << 1);
            end
            DIG_NEG: begin
                o_q  = (i_qm << 1) | ONE;
                o_qm = (i_qm << 1);
            end
            DIG_ZERO: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/otf_convert_hd.sv
// Converts a stream of signed quotient digits (MSD first) into DIGITS-digit
// two's-complement words, with a one-entry output register and a HOLD stall.
module otf_convert_hd
    import otf_hd_pkg::*;
#(
    parameter int DIGITS = 32
) (
    input  logic             clk,
    input  logic             asyn_reset,
    otf_convert_hd_if.slave  bus,
    output logic [0:0]       o_dbg_state
);

    localparam int W  = DIGITS + 1;
    localparam int CW = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST  = CW'(DIGITS - 1);
    localparam logic [W-1:0]  Q_INIT  = '0;
    localparam logic [W-1:0]  QM_INIT = '1;

    logic [W-1:0]  r_q;
    logic [W-1:0]  r_qm;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic          r_out_full;
    logic          r_alive;

    logic [W-1:0]  w_q_next;
    logic [W-1:0]  w_qm_next;
    logic          w_acc;
    logic          w_out_hs;
    logic          w_done;
    logic          w_load_new;
    logic          w_load_held;
    logic          w_to_hold;
    logic          w_reinit;

    otf_step #(.W(W)) u_step (
        .i_q     (r_q),
        .i_qm    (r_qm),
        .i_digit (bus.q_value),
        .o_q     (w_q_next),
        .o_qm    (w_qm_next)
    );

    // r_alive keeps data_in_rdy low during reset and until the first edge after it.
    assign bus.data_in_rdy  = r_alive & (r_state == ACCUM);
    assign bus.data_out_vld = r_out_full;
    assign bus.result_value = r_result;
    assign o_dbg_state      = r_state;

    assign w_acc       = bus.data_in_vld & bus.data_in_rdy;
    assign w_out_hs    = r_out_full & bus.data_out_rdy;
    assign w_done      = w_acc & (r_count == LAST);
    assign w_load_new  = w_done & (~r_out_full | w_out_hs);
    assign w_to_hold   = w_done & r_out_full & ~w_out_hs;
    assign w_load_held = (r_state == HOLD) & w_out_hs;
    assign w_reinit    = w_load_new | w_load_held;

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_q        <= Q_INIT;
            r_qm       <= QM_INIT;
            r_result   <= '0;
            r_count    <= '0;
            r_state    <= ACCUM;
            r_out_full <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_alive <= 1'b1;

            if (w_reinit) begin
                r_q  <= Q_INIT;
                r_qm <= QM_INIT;
            end else if (w_acc) begin
                r_q  <= w_q_next;
                r_qm <= w_qm_next;
            end

            if (w_reinit || w_done) begin
                r_count <= '0;
            end else if (w_acc) begin
                r_count <= r_count + CW'(1);
            end

            // A completed word goes straight out if the slot is free or freeing now;
            // otherwise it parks in Q until the consumer takes the current word.
            if (w_load_new) begin
                r_result <= w_q_next;
            end else if (w_load_held) begin
                r_result <= r_q;
            end

            if (w_reinit) begin
                r_out_full <= 1'b1;
            end else if (w_out_hs) begin
                r_out_full <= 1'b0;
            end

            if (w_to_hold) begin
                r_state <= HOLD;
            end else if (w_load_held) begin
                r_state <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_otf_convert_hd.sv
// Bench for otf_convert_hd: directed DIGITS=4 cases plus a randomized DIGITS=32 run.
module tb_otf_convert_hd;
    import otf_hd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    otf_convert_hd_if #(.DIGITS(4))  bus4 ();
    otf_convert_hd_if #(.DIGITS(32)) bus32 ();
    logic [0:0] dbg4;
    logic [0:0] dbg32;

    otf_convert_hd #(.DIGITS(4)) dut4 (
        .clk (clk), .asyn_reset (rst), .bus (bus4), .o_dbg_state (dbg4)
    );
    otf_convert_hd #(.DIGITS(32)) dut32 (
        .clk (clk), .asyn_reset (rst), .bus (bus32), .o_dbg_state (dbg32)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0]  exp4_q[$];
    logic [32:0] exp32_q[$];
    longint acc4 = 0;
    longint acc32 = 0;
    int cnt4 = 0;
    int cnt32 = 0;
    int words32 = 0;
    logic rand32_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint dval(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    // Reference: word value times 2^DIGITS, accumulated MSD first; low DIGITS+1 bits are the result.
    task automatic model4(input logic [1:0] d);
        acc4 = acc4 * 2 + dval(d);
        cnt4++;
        if (cnt4 == 4) begin
            exp4_q.push_back(acc4[4:0]);
            acc4 = 0;
            cnt4 = 0;
        end
    endtask

    task automatic model32(input logic [1:0] d);
        acc32 = acc32 * 2 + dval(d);
        cnt32++;
        if (cnt32 == 32) begin
            exp32_q.push_back(acc32[32:0]);
            acc32 = 0;
            cnt32 = 0;
        end
    endtask

    // Driver tasks are entered and left one time unit after a rising edge.
    task automatic drive4(input logic [1:0] d);
        int waitc;
        waitc = 0;
        bus4.q_value     = d;
        bus4.data_in_vld = 1'b1;
        @(negedge clk);
        while (!bus4.data_in_rdy && waitc < 64) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus4.data_in_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive4_timeout: data_in_rdy still 0 after %0d cycles, required 1", waitc);
        end else begin
            @(posedge clk);
            #1;
            model4(d);
        end
        bus4.data_in_vld = 1'b0;
        bus4.q_value     = 2'($urandom_range(0, 3));
        if (waitc >= 64) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive32(input logic [1:0] d);
        int waitc;
        waitc = 0;
        bus32.q_value     = d;
        bus32.data_in_vld = 1'b1;
        @(negedge clk);
        while (!bus32.data_in_rdy && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus32.data_in_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive32_timeout: data_in_rdy still 0 after %0d cycles, required 1", waitc);
        end else begin
            @(posedge clk);
            #1;
            model32(d);
        end
        bus32.data_in_vld = 1'b0;
        bus32.q_value     = 2'($urandom_range(0, 3));
        if (waitc >= 200) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic digits4(input logic [7:0] ds);
        for (int i = 0; i < 4; i++) begin
            drive4(ds[7-2*i -: 2]);
        end
    endtask

    // Sends a word with data_out_rdy high and checks latency, pulse width and value.
    task automatic word4(input string name, input logic [7:0] ds, input logic [4:0] exp_val);
        int pulses;
        logic first;
        logic [4:0] got;
        pulses = 0;
        first  = 1'b0;
        got    = '0;
        digits4(ds);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus4.data_out_vld) begin
                pulses++;
                if (k == 0) begin
                    first = 1'b1;
                    got   = bus4.result_value;
                end
            end
        end
        check({name, "_latency"}, 64'(first), 64'd1);
        check({name, "_pulse"}, 64'(pulses), 64'd1);
        check({name, "_value"}, 64'(got), 64'(exp_val));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (!rst && bus4.data_out_vld && bus4.data_out_rdy) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out4_extra: got word %0h with nothing expected", bus4.result_value);
            end else begin
                check("out4_word", 64'(bus4.result_value), 64'(exp4_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus32.data_out_vld && bus32.data_out_rdy) begin
            words32++;
            if (exp32_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out32_extra: got word %0h with nothing expected", bus32.result_value);
            end else begin
                check("out32_word", 64'(bus32.result_value), 64'(exp32_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand32_on) bus32.data_out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [4:0] held;
        int waitc;
        rst = 1'b1;
        bus4.q_value = '0;  bus4.data_in_vld = 1'b0;  bus4.data_out_rdy = 1'b0;
        bus32.q_value = '0; bus32.data_in_vld = 1'b0; bus32.data_out_rdy = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_rdy", 64'(bus4.data_in_rdy), 64'd0);
        check("rst_out_vld", 64'(bus4.data_out_vld), 64'd0);
        check("rst_result", 64'(bus4.result_value), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", 64'(bus4.data_in_rdy), 64'd1);
        check("post_rst_state", 64'(dbg4), 64'(ACCUM));
        @(posedge clk);
        #1;

        // Basic words with consumer always ready
        bus4.data_out_rdy = 1'b1;
        word4("w_pz_np", 8'b10_00_01_10, 5'b00111);
        word4("w_neg4", 8'b01_01_01_01, 5'b10001);
        word4("w_zeros", 8'b00_11_00_11, 5'b00000);

        // Back-to-back words with consumer stalled: second word parks in HOLD
        bus4.data_out_rdy = 1'b0;
        digits4(8'b10_10_00_00);
        digits4(8'b01_00_00_10);
        @(negedge clk);
        check("hold_state", 64'(dbg4), 64'(HOLD));
        check("hold_in_rdy", 64'(bus4.data_in_rdy), 64'd0);
        check("hold_out_vld", 64'(bus4.data_out_vld), 64'd1);
        check("hold_first_word", 64'(bus4.result_value), 64'h0c);
        held = bus4.result_value;
        bus4.q_value = 2'b10;
        bus4.data_in_vld = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_stable", 64'(bus4.result_value), 64'(held));
        check("hold_still_in_rdy", 64'(bus4.data_in_rdy), 64'd0);
        bus4.data_in_vld = 1'b0;
        @(posedge clk);
        #1;
        bus4.data_out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("release_in_rdy", 64'(bus4.data_in_rdy), 64'd1);
        check("release_state", 64'(dbg4), 64'(ACCUM));
        check("release_out_vld", 64'(bus4.data_out_vld), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-word with a full output register
        bus4.data_out_rdy = 1'b0;
        digits4(8'b00_10_00_00);
        drive4(2'b10);
        drive4(2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vld", 64'(bus4.data_out_vld), 64'd0);
        check("async_rst_result", 64'(bus4.result_value), 64'd0);
        check("async_rst_in_rdy", 64'(bus4.data_in_rdy), 64'd0);
        exp4_q.delete();
        exp32_q.delete();
        acc4 = 0; cnt4 = 0; acc32 = 0; cnt32 = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus4.data_out_rdy = 1'b1;
        word4("w_after_rst", 8'b10_10_10_10, 5'b01111);

        // Randomized DIGITS=32 run: random input gaps and random consumer stalls
        rand32_on = 1'b1;
        for (int w = 0; w < 100; w++) begin
            for (int i = 0; i < 32; i++) begin
                while ($urandom_range(0, 1) == 1) begin
                    bus32.data_in_vld = 1'b0;
                    bus32.q_value = 2'($urandom_range(0, 3));
                    @(posedge clk);
                    #1;
                end
                drive32(2'($urandom_range(0, 3)));
            end
        end
        rand32_on = 1'b0;
        bus32.data_out_rdy = 1'b1;
        waitc = 0;
        while ((exp32_q.size() != 0 || exp4_q.size() != 0) && waitc < 2000) begin
            @(posedge clk);
            waitc++;
        end
        repeat (2) @(negedge clk);
        check("q32_drained", 64'(exp32_q.size()), 64'd0);
        check("q4_drained", 64'(exp4_q.size()), 64'd0);
        check("words32_count", 64'(words32), 64'd100);
        check("end_out_vld32", 64'(bus32.data_out_vld), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otf_convert_hd.md
OTF_CONVERT_HD -- requirements
Module: otf_convert_hd

Interface
REQ-001 SHALL have parameter DIGITS, default 32: quotient digits per word, range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port asyn_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port q_value, input, 2 bits: one signed quotient digit from the online divider, most significant digit first.
REQ-005 SHALL have port data_in_vld, input, 1 bit: q_value is valid.
REQ-006 SHALL have port data_in_rdy, output, 1 bit: block accepts a digit this cycle.
REQ-007 SHALL have port result_value, output, DIGITS+1 bits: two's-complement quotient, sign bit plus DIGITS fraction bits (value = result_value * 2^-DIGITS).
REQ-008 SHALL have port data_out_vld, output, 1 bit: result_value is valid.
REQ-009 SHALL have port data_out_rdy, input, 1 bit: consumer accepts result_value.

Function
REQ-010 SHALL decode digits as {p,n}, value p-n: 2'b10 = +1, 2'b01 = -1, 2'b00 and 2'b11 = 0.
REQ-011 SHALL accept a digit only when data_in_vld and data_in_rdy are both high at a rising edge.
REQ-012 SHALL keep two DIGITS+1-bit registers: Q (init all zeros) and QM (init all ones).
REQ-013 SHALL update Q and QM on each accepted digit by left-shifting and appending, MSB discarded:
- +1: Q={Q,1}, QM={Q,0}
- 0: Q={Q,0}, QM={QM,1}
- -1: Q={QM,1}, QM={QM,0}
REQ-014 SHALL count accepted digits modulo DIGITS; the DIGITS-th accepted digit completes a word.
REQ-015 SHALL hold a one-entry output register (result_value, out_full); data_out_vld = out_full.
REQ-016 On word completion with out_full low, or with an output handshake in the same cycle, SHALL:
- load the final Q into the output register;
- set out_full;
- reinitialise Q, QM and the count in that edge;
- stay in state ACCUM.
REQ-017 On word completion with out_full high and no output handshake, SHALL keep the completed Q and enter state HOLD.
REQ-018 SHALL drive data_in_rdy high in ACCUM and low in HOLD.
REQ-019 In HOLD, on an output handshake, SHALL load the held Q into the output register, reinitialise Q, QM and the count, and return to ACCUM.
REQ-020 SHALL clear out_full on an output handshake unless it is reloaded in the same edge.
REQ-021 SHALL hold result_value and data_out_vld stable while data_out_vld is high and data_out_rdy is low.
REQ-022 Latency: data_out_vld SHALL rise one cycle after the last digit is accepted, when out_full was low.
REQ-023 SHALL sustain one digit per cycle continuously when data_out_rdy is held high.
REQ-024 SHALL ignore q_value whenever no digit handshake occurs.

Reset
REQ-025 While asyn_reset is high, SHALL immediately force all of the following, independent of clk:
- Q=0, QM=all ones, count=0, state ACCUM;
- out_full=0, result_value=0, data_out_vld=0, data_in_rdy=0.
REQ-026 After asyn_reset falls, SHALL raise data_in_rdy at the first rising edge; a partial word in progress at reset SHALL be discarded.

Structure
REQ-027 SHALL take the following from shared package otf_hd_pkg, shared with the divider:
- digit encoding constants DIG_POS, DIG_NEG, DIG_ZERO;
- state encoding ACCUM, HOLD.
REQ-028 SHALL implement the Q/QM next-value rule as one combinational sub-module otf_step, parameterised by width.
REQ-029 SHALL size the digit counter as $clog2(DIGITS) bits.

Verification (DIGITS=4 unless stated)
REQ-030 Digits +1,0,-1,+1, data_out_rdy=1 -> result_value=5'b00111 (7/16), data_out_vld high for one cycle.
REQ-031 Digits -1,-1,-1,-1 -> 5'b10001; digits 00,11,00,11 -> 5'b00000.
REQ-032 Two words back-to-back, data_out_rdy=0 -> first word held stable, second word completes, data_in_rdy low (HOLD). Then data_out_rdy=1 -> words delivered in order, data_in_rdy high again.
REQ-033 asyn_reset pulse mid-edge after 2 digits, then 4 new digits +1,+1,+1,+1 -> result_value=5'b01111; no stale data; outputs zero during reset.
REQ-034 data_in_vld toggled randomly, DIGITS=32, 100 words -> every result matches a reference model (sum of digit_i * 2^-i); no word lost or duplicated.
